// File: rtl/match_controller.sv
// Match supervisor: lives/HP bookkeeping for NUM_PLAYERS fighters, READY/PLAY/PAUSE/ENDGAME flow,
// winner/draw reporting. Registered state/outputs; screen and alive decode combinationally.
module match_controller #(
  parameter int NUM_PLAYERS  = 2,
  parameter int LIVES        = 3,
  parameter int LIFE_W       = 3,
  parameter int HP_W         = 12,
  parameter int DAMAGE       = 1,
  parameter int HIT_COOLDOWN = 8,
  parameter int CD_W         = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_req,
  input  logic                          pause_req,
  input  logic                          restart_req,
  input  logic [NUM_PLAYERS-1:0]        hit,
  input  logic [NUM_PLAYERS-1:0]        death,
  output logic [NUM_PLAYERS*LIFE_W-1:0] lives,
  output logic [NUM_PLAYERS*HP_W-1:0]   hp,
  output logic [NUM_PLAYERS-1:0]        alive,
  output logic [NUM_PLAYERS-1:0]        hit_ack,
  output logic [1:0]                    screen,
  output logic [1:0]                    winner,
  output logic                          draw
);

  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_END   = 2'b11
  } state_t;

  localparam logic [HP_W:0] DMG_EXT = (HP_W+1)'(DAMAGE);

  state_t                 state, state_nxt;
  logic [NUM_PLAYERS-1:0] death_q;
  logic                   pause_q;
  logic [CD_W-1:0]        cd [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] death_ev;
  logic                   pause_edge;
  logic [2:0]             n_alive;
  logic [1:0]             sole_idx;
  logic                   game_over;

  // Falling edge of death: one event per out-of-bounds excursion.
  assign death_ev   = death_q & ~death;
  assign pause_edge = pause_req & ~pause_q;

  function automatic logic [HP_W-1:0] sat_add(input logic [HP_W-1:0] h);
    logic [HP_W:0] s;
    s = {1'b0, h} + DMG_EXT;
    return s[HP_W] ? '1 : s[HP_W-1:0];
  endfunction

  always_comb begin
    alive    = '0;
    n_alive  = '0;
    sole_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      alive[i] = |lives[i*LIFE_W +: LIFE_W];
      n_alive  = n_alive + {2'b00, alive[i]};
      if (alive[i]) sole_idx = 2'(i);
    end
    game_over = (n_alive <= 3'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_READY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_READY: if (start_req) state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (game_over)       state_nxt = ST_END;
        else if (pause_edge) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: if (pause_edge)  state_nxt = ST_PLAY;
      ST_END:   if (restart_req) state_nxt = ST_READY;
      default:  state_nxt = ST_READY;
    endcase
  end

  always_comb begin
    screen = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        lives[i*LIFE_W +: LIFE_W] <= LIFE_W'(LIVES);
        cd[i]                     <= '0;
      end
      hp      <= '0;
      hit_ack <= '0;
      winner  <= '0;
      draw    <= 1'b0;
      death_q <= '0;
      pause_q <= 1'b0;
    end else begin
      death_q <= death;
      pause_q <= pause_req;
      hit_ack <= '0;
      case (state)
        ST_READY: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            lives[i*LIFE_W +: LIFE_W] <= LIFE_W'(LIVES);
            hp[i*HP_W +: HP_W]        <= '0;
            cd[i]                     <= '0;
          end
        end
        ST_PLAY: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive[i]) begin
              if (death_ev[i]) begin
                lives[i*LIFE_W +: LIFE_W] <= lives[i*LIFE_W +: LIFE_W] - LIFE_W'(1);
                hp[i*HP_W +: HP_W]        <= '0;
                cd[i]                     <= '0;
              end else if (hit[i] && cd[i] == '0) begin
                hp[i*HP_W +: HP_W] <= sat_add(hp[i*HP_W +: HP_W]);
                cd[i]              <= CD_W'(HIT_COOLDOWN);
                hit_ack[i]         <= 1'b1;
              end else if (cd[i] != '0) begin
                cd[i] <= cd[i] - CD_W'(1);
              end
            end
          end
          // Survivor count comes from registered lives, hence the one-cycle lag into ENDGAME.
          if (game_over) begin
            winner <= (n_alive == 3'd0) ? 2'b00 : sole_idx;
            draw   <= (n_alive == 3'd0);
          end
        end
        ST_END: begin
          if (restart_req) begin
            winner <= '0;
            draw   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
Parametrised match supervisor that succeeds the two-player control logic. It tracks lives and accumulated damage (HP) for NUM_PLAYERS fighters and runs the READY/PLAY/PAUSE/ENDGAME screen flow. It reports the winner or a draw. Collision and key decoding stay upstream: the block consumes per-player hit and death request vectors plus start, pause and restart requests, and feeds the HUD and screen mux.

Parameters:
NUM_PLAYERS, 2, number of fighters; legal 2..4.
LIVES, 3, lives loaded at match start; legal 1..7.
LIFE_W, 3, lives counter width; must hold LIVES.
HP_W, 12, damage counter width.
DAMAGE, 1, HP added per accepted hit.
HIT_COOLDOWN, 8, cycles a player is immune after an accepted hit; 0 disables immunity.
CD_W, 8, cooldown counter width; must hold HIT_COOLDOWN.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_req  in  1  level; begins a match from READY
pause_req  in  1  level; each rising edge toggles PLAY/PAUSE
restart_req  in  1  level; ENDGAME -> READY
hit  in  NUM_PLAYERS  bit i = player i is being struck this cycle
death  in  NUM_PLAYERS  bit i = player i out of bounds (multi-cycle level)
lives  out  NUM_PLAYERS*LIFE_W  player i in slice [i*LIFE_W +: LIFE_W]
hp  out  NUM_PLAYERS*HP_W  player i in slice [i*HP_W +: HP_W]
alive  out  NUM_PLAYERS  bit i = lives of player i nonzero
hit_ack  out  NUM_PLAYERS  one-cycle pulse per accepted hit
screen  out  2  00 READY, 01 PLAY, 10 PAUSE, 11 ENDGAME
winner  out  2  index of surviving player; valid in ENDGAME when draw=0
draw  out  1  ENDGAME reached with zero survivors

Behaviour:
- Reset (reset low, async):
  - state READY; all lives=LIVES, hp=0, cooldowns=0.
  - hit_ack=0, winner=0, draw=0.
  - Edge-detect registers for death and pause cleared to 0.
- Registered outputs: lives, hp, hit_ack, winner, draw.
- Combinational outputs: screen (from state), alive (from registered lives).
- Edge detection:
  - death_q[i] and pause_q sample their inputs every cycle in every state.
  - death event i = death_q[i] & ~death[i], i.e. a falling edge, so one event per out-of-bounds excursion regardless of its length.
  - pause edge = pause_req & ~pause_q.
- READY:
  - lives reloaded to LIVES, hp and cooldowns cleared every cycle.
  - start_req=1 -> PLAY at next edge.
- PLAY, per player i, priority order:
  1. Death event with lives>0: lives decrement by 1, hp=0, cooldown=0, hit_ack=0. A same-cycle hit is dropped.
  2. Otherwise hit[i]=1, cooldown=0 and lives>0: hp = min(hp+DAMAGE, 2^HP_W-1) (saturating, never wraps); cooldown=HIT_COOLDOWN; hit_ack pulses next cycle.
  3. A nonzero cooldown decrements by 1 each PLAY cycle. Hits while the cooldown is nonzero are ignored.
- Eliminated players (lives=0) ignore hits and deaths; their hp is held at 0.
- Transitions from PLAY:
  - Survivor count (popcount of alive) <=1 -> ENDGAME at the next edge.
  - This is evaluated on registered lives, so ENDGAME is entered one cycle after the final decrement.
  - On that transition: winner = index of the sole survivor and draw=0. With zero survivors (simultaneous final deaths): winner=0, draw=1.
  - A pause edge and game-over in the same cycle: ENDGAME wins.
- PAUSE:
  - lives, hp and cooldowns are frozen.
  - Death and hit events are discarded; the edge registers keep sampling, so no stale event fires on resume.
  - Pause edge -> PLAY.
- ENDGAME:
  - lives, hp, winner and draw are held.
  - restart_req=1 -> READY; winner and draw clear on entry to READY.
- start_req held through READY->PLAY has no further effect. restart_req in any state other than ENDGAME is ignored.
- Reset asserted mid-match: immediate return to reset values; no partial update.
- Unused winner bits are 0 when NUM_PLAYERS=2.

Test Plan:
- Reset low, then high; start_req 1 cycle -> screen 00 then 01; lives all 3; hp all 0.
- NUM_PLAYERS=2, HIT_COOLDOWN=8: hit[1] held 20 cycles -> hp[1]=3, hit_ack[1] pulses at cycles 1, 10 and 19 after onset.
- death[0] high 50 cycles then low -> a single decrement, lives[0]=2, hp[0]=0; repeat twice more -> screen 11 one cycle later, winner=1, draw=0.
- Both players at 1 life, death falls on both in the same cycle -> both lives 0, screen 11, draw=1; restart_req -> screen 00 with lives reloaded.
- Mid-PLAY pause edge -> screen 10; hits and a full death pulse during pause leave lives/hp unchanged; second pause edge -> screen 01, and no event fires.
- HP_W=4, DAMAGE=5: 4 accepted hits -> hp=15 (saturated); NUM_PLAYERS=4 with players 0, 1 and 3 eliminated -> winner=2.
